// File: rtl/bf_bus_responder.sv
// -----------------------------------------------------------------------------
// bf_bus_responder
//
// Purpose:
//   Host-side responder for a byte-wide chip bus. The chip presents a phase
//   code and a bus byte. The responder steps through opcode, address-high,
//   address-low and read/write phases. It then services the transaction in
//   one of three ways:
//     - a memory request (data read, data write, program read),
//     - an output-byte stream handshake, or
//     - an input-byte stream handshake.
//   It returns a one-cycle op_done pulse with the captured byte.
//   Any protocol violation, illegal code or memory timeout parks the block
//   in a sticky error state until reset.
//
// Ports:
//   clock, reset          sole clock; asynchronous active-low reset
//   chip_out[11:0]        [11] halted, [10:8] phase, [7:0] bus
//   chip_in[11:0]         [7:0] read data, [8] op_done, [9] enable, [11:10] 0
//   run                   host permission to start new transactions
//   mem_req/we/prog       memory request controls (prog selects program space)
//   mem_addr[14:0]        latched transaction address
//   mem_wdata[7:0]        write data (chip bus during a data write)
//   mem_rdata, mem_ack    memory read data and completion
//   out_valid/data/ready  output-byte stream
//   in_valid/data/ready   input-byte stream
//   halted, proto_err     status: registered chip halt, sticky error
//   op_count[15:0]        completed transactions, wrapping
// -----------------------------------------------------------------------------
module bf_bus_responder #(
    parameter int MAX_WAIT = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] chip_out,
    output logic [11:0] chip_in,
    input  logic        run,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_prog,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        halted,
    output logic        proto_err,
    output logic [15:0] op_count
);

    // The wait counter only needs to hold MAX_WAIT-1.
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    localparam logic [2:0] PH_NONE   = 3'd0;
    localparam logic [2:0] PH_OPCODE = 3'd1;
    localparam logic [2:0] PH_ADDRHI = 3'd2;
    localparam logic [2:0] PH_ADDRLO = 3'd3;
    localparam logic [2:0] PH_RW     = 3'd4;

    localparam logic [2:0] OP_DREAD  = 3'd1;
    localparam logic [2:0] OP_DWRITE = 3'd2;
    localparam logic [2:0] OP_PREAD  = 3'd3;
    localparam logic [2:0] OP_OUTPUT = 3'd4;
    localparam logic [2:0] OP_INPUT  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_HI = 3'd1,
        S_ADDR_LO = 3'd2,
        S_RW      = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_en;
    logic                w_next_en;
    logic [2:0]          r_opcode;
    logic [2:0]          w_next_opcode;
    logic [14:0]         r_addr;
    logic [14:0]         w_next_addr;
    logic [7:0]          r_data;
    logic [7:0]          w_next_data;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_next_wait;
    logic                r_halted;
    logic [15:0]         r_op_count;

    logic [2:0]          w_phase;
    logic [7:0]          w_bus;

    assign w_phase = chip_out[10:8];
    assign w_bus   = chip_out[7:0];

    // Next-state, latched fields and the enable to present next cycle.
    always_comb begin
        w_next_state  = r_state;
        w_next_opcode = r_opcode;
        w_next_addr   = r_addr;
        w_next_data   = r_data;
        w_next_wait   = r_wait;
        case (r_state)
            S_IDLE: begin
                // The chip is only sampled while it sees enable high.
                if (r_en) begin
                    if (w_phase == PH_OPCODE) begin
                        w_next_opcode = w_bus[2:0];
                        w_next_state  = S_ADDR_HI;
                    end else if (w_phase == PH_NONE) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_ERR;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ADDR_HI: begin
                // Address is 15 bits; bus[7] carries nothing here.
                if (w_phase == PH_ADDRHI) begin
                    w_next_addr[14:8] = w_bus[6:0];
                    w_next_state      = S_ADDR_LO;
                end else begin
                    w_next_state = S_ERR;
                end
            end
            S_ADDR_LO: begin
                if (w_phase == PH_ADDRLO) begin
                    w_next_addr[7:0] = w_bus;
                    w_next_wait      = '0;
                    w_next_data      = 8'h00;
                    w_next_state     = S_RW;
                end else begin
                    w_next_state = S_ERR;
                end
            end
            S_RW: begin
                if (w_phase != PH_RW) begin
                    w_next_state = S_ERR;
                end else begin
                    case (r_opcode)
                        OP_DREAD, OP_DWRITE, OP_PREAD: begin
                            // Ack wins over the timeout on the last allowed cycle.
                            if (mem_ack) begin
                                w_next_data  = (r_opcode == OP_DWRITE) ? 8'h00 : mem_rdata;
                                w_next_state = S_DONE;
                            end else if (r_wait == WAIT_LAST) begin
                                w_next_state = S_ERR;
                            end else begin
                                w_next_wait = r_wait + WAIT_W'(1);
                            end
                        end
                        OP_OUTPUT: begin
                            if (out_ready) begin
                                w_next_data  = 8'h00;
                                w_next_state = S_DONE;
                            end else begin
                                w_next_state = S_RW;
                            end
                        end
                        OP_INPUT: begin
                            if (in_valid) begin
                                w_next_data  = in_data;
                                w_next_state = S_DONE;
                            end else begin
                                w_next_state = S_RW;
                            end
                        end
                        default: begin
                            w_next_state = S_ERR;
                        end
                    endcase
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            S_ERR: begin
                w_next_state = S_ERR;
            end
            default: begin
                w_next_state = S_ERR;
            end
        endcase

        // Enable is registered, so it reflects the state being entered.
        case (w_next_state)
            S_IDLE:  w_next_en = run & ~chip_out[11];
            S_ERR:   w_next_en = 1'b0;
            default: w_next_en = 1'b1;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_en       <= 1'b0;
            r_opcode   <= 3'd0;
            r_addr     <= 15'd0;
            r_data     <= 8'h00;
            r_wait     <= '0;
            r_halted   <= 1'b0;
            r_op_count <= 16'd0;
        end else begin
            r_state    <= w_next_state;
            r_en       <= w_next_en;
            r_opcode   <= w_next_opcode;
            r_addr     <= w_next_addr;
            r_data     <= w_next_data;
            r_wait     <= w_next_wait;
            r_halted   <= chip_out[11];
            r_op_count <= (r_state == S_DONE) ? (r_op_count + 16'd1) : r_op_count;
        end
    end

    // Output decode from registered state; the bus byte passes through only in RW.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_prog  = 1'b0;
        mem_wdata = 8'h00;
        out_valid = 1'b0;
        out_data  = 8'h00;
        in_ready  = 1'b0;
        if (r_state == S_RW) begin
            case (r_opcode)
                OP_DREAD: begin
                    mem_req = 1'b1;
                end
                OP_DWRITE: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = w_bus;
                end
                OP_PREAD: begin
                    mem_req  = 1'b1;
                    mem_prog = 1'b1;
                end
                OP_OUTPUT: begin
                    out_valid = 1'b1;
                    out_data  = w_bus;
                end
                OP_INPUT: begin
                    in_ready = 1'b1;
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end else begin
            mem_req = 1'b0;
        end
    end

    assign mem_addr  = r_addr;
    assign chip_in   = {2'b00, r_en, (r_state == S_DONE),
                        (r_state == S_DONE) ? r_data : 8'h00};
    assign halted    = r_halted;
    assign proto_err = (r_state == S_ERR);
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_bf_bus_responder.sv
module tb_bf_bus_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] chip_out;
    logic [11:0] chip_in;
    logic        run;
    logic        mem_req, mem_we, mem_prog;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        halted, proto_err;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bf_bus_responder dut (
        .clock     (clock),
        .reset     (reset),
        .chip_out  (chip_out),
        .chip_in   (chip_in),
        .run       (run),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_prog  (mem_prog),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .halted    (halted),
        .proto_err (proto_err),
        .op_count  (op_count)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the opcode/address phases; returns settled in the first RW cycle.
    task automatic start_txn(input logic [2:0] op, input logic [7:0] hi,
                             input logic [7:0] lo, input logic [7:0] rw_bus);
        int n;
        n = 0;
        while (chip_in[9] !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk("enable_before_txn", chip_in[9], 1);
        chip_out = {1'b0, 3'd1, 5'd0, op};
        tick;
        chip_out = {1'b0, 3'd2, hi};
        tick;
        chip_out = {1'b0, 3'd3, lo};
        tick;
        chip_out = {1'b0, 3'd4, rw_bus};
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b0;
        chip_out  = 12'h000;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        tick;
        tick;
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int bad;
        reset     = 1'b0;
        run       = 1'b0;
        chip_out  = 12'h000;
        mem_rdata = 8'h00;
        mem_ack   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        #12;
        // Reset state
        chk("rst_chip_in", chip_in, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_halted", halted, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_op_count", op_count, 0);
        tick;
        reset = 1'b1;
        tick;
        chk("en_low_run0", chip_in[9], 0);
        run = 1'b1;
        tick;
        chk("en_rise_run1", chip_in[9], 1);

        // Chip halted in IDLE blocks enable
        chip_out = 12'h800;
        tick;
        chk("halted_set", halted, 1);
        chk("halted_en_low", chip_in[9], 0);
        chip_out = 12'h000;
        tick;
        chk("halted_clr", halted, 0);
        chk("halted_en_back", chip_in[9], 1);

        // Data read at 0x1234, ack on third RW cycle, run dropped mid-way
        start_txn(3'd1, 8'h12, 8'h34, 8'h00);
        run = 1'b0;
        chk("rd_mem_req", mem_req, 1);
        chk("rd_mem_addr", mem_addr, 15'h1234);
        chk("rd_mem_prog", mem_prog, 0);
        chk("rd_mem_we", mem_we, 0);
        tick;
        tick;
        chk("rd_no_stall", chip_in[9], 1);
        chk("rd_no_done_yet", chip_in[8], 0);
        mem_ack = 1'b1;
        mem_rdata = 8'hA5;
        #1;
        chk("rd_req_ack_cycle", mem_req, 1);
        tick;
        mem_ack = 1'b0;
        run = 1'b1;
        chip_out = 12'h000;
        #1;
        chk("rd_done", chip_in[8], 1);
        chk("rd_data", chip_in[7:0], 8'hA5);
        chk("rd_req_dropped", mem_req, 0);
        tick;
        chk("rd_done_one_cycle", chip_in[8:0], 0);
        chk("rd_op_count", op_count, 1);

        // Data write at 0x7FFF (bus[7] of high byte ignored), ack immediately
        start_txn(3'd2, 8'hFF, 8'hFF, 8'h3C);
        mem_ack = 1'b1;
        mem_rdata = 8'h99;
        #1;
        chk("wr_mem_req", mem_req, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_wdata", mem_wdata, 8'h3C);
        chk("wr_mem_addr", mem_addr, 15'h7FFF);
        tick;
        mem_ack = 1'b0;
        chip_out = 12'h000;
        #1;
        chk("wr_done", chip_in[8], 1);
        chk("wr_data_zero", chip_in[7:0], 8'h00);
        tick;
        chk("wr_op_count", op_count, 2);

        // Output stream with long backpressure
        start_txn(3'd4, 8'h00, 8'h00, 8'h41);
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            if (out_valid !== 1'b1 || out_data !== 8'h41 || chip_in[8] !== 1'b0) bad++;
            tick;
        end
        chk("out_hold_bad_cycles", bad, 0);
        chk("out_no_err", proto_err, 0);
        chk("out_valid_held", out_valid, 1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chip_out = 12'h000;
        #1;
        chk("out_done", chip_in[8:0], 9'h100);
        chk("out_valid_dropped", out_valid, 0);
        tick;
        chk("out_op_count", op_count, 3);

        // Input stream, data offered after 10 cycles
        start_txn(3'd5, 8'h00, 8'h00, 8'h00);
        chk("in_ready_first", in_ready, 1);
        repeat (10) tick;
        chk("in_ready_held", in_ready, 1);
        in_valid = 1'b1;
        in_data = 8'h7A;
        tick;
        in_valid = 1'b0;
        chip_out = 12'h000;
        #1;
        chk("in_done", chip_in[8:0], 9'h17A);
        chk("in_ready_dropped", in_ready, 0);
        tick;
        chk("in_op_count", op_count, 4);

        // Program read interrupted by reset
        start_txn(3'd3, 8'h01, 8'h02, 8'h00);
        chk("pr_mem_prog", mem_prog, 1);
        chk("pr_mem_req", mem_req, 1);
        chk("pr_mem_addr", mem_addr, 15'h0102);
        #2;
        reset = 1'b0;
        #1;
        chk("pr_rst_chip_in", chip_in, 0);
        chk("pr_rst_mem_req", mem_req, 0);
        chk("pr_rst_mem_prog", mem_prog, 0);
        chk("pr_rst_mem_addr", mem_addr, 0);
        chk("pr_rst_op_count", op_count, 0);
        do_reset;

        // Memory timeout
        start_txn(3'd1, 8'h00, 8'h10, 8'h00);
        n = 0;
        while (proto_err !== 1'b1 && n < 1100) begin
            tick;
            n++;
        end
        chk("to_rw_cycles", n, 1023);
        chk("to_en_low", chip_in[9], 0);
        chk("to_mem_req", mem_req, 0);
        repeat (3) tick;
        chk("to_sticky", proto_err, 1);
        do_reset;
        tick;
        chk("to_cleared", proto_err, 0);

        // Phase jump 1 -> 3
        n = 0;
        while (chip_in[9] !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chip_out = {1'b0, 3'd1, 8'h01};
        tick;
        chip_out = {1'b0, 3'd3, 8'h00};
        tick;
        chk("jump_err", proto_err, 1);
        chk("jump_en_low", chip_in[9], 0);
        do_reset;

        // Illegal opcode 7
        start_txn(3'd7, 8'h00, 8'h00, 8'h00);
        chk("ill_no_req", mem_req, 0);
        tick;
        chk("ill_err", proto_err, 1);
        chk("ill_no_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
